// File: rtl/ex_mem_if.sv
// EX/MEM stage bus: EX-side capture inputs, WB forwarding inputs, pipeline control and EM outputs.
interface ex_mem_if;
    logic        stall;
    logic        flush;
    logic        EX_Valid;
    logic [31:0] EX_ALUResult;
    logic [31:0] EX_WriteData;
    logic [4:0]  EX_Rt;
    logic [4:0]  EX_WriteReg;
    logic        EX_MemRead;
    logic        EX_MemWrite;
    logic        EX_RegWrite;
    logic        EX_MemtoReg;
    logic        WB_RegWrite;
    logic [4:0]  WB_WriteReg;
    logic [31:0] WB_Result;
    logic        EM_Valid;
    logic [31:0] EM_ALUResult;
    logic [31:0] EM_WriteData;
    logic [4:0]  EM_Rt;
    logic [4:0]  EM_WriteReg;
    logic        EM_MemRead;
    logic        EM_MemWrite;
    logic        EM_RegWrite;
    logic        EM_MemtoReg;
    logic        EM_Fault;

    modport master (
        output stall, flush, EX_Valid, EX_ALUResult, EX_WriteData, EX_Rt, EX_WriteReg,
               EX_MemRead, EX_MemWrite, EX_RegWrite, EX_MemtoReg,
               WB_RegWrite, WB_WriteReg, WB_Result,
        input  EM_Valid, EM_ALUResult, EM_WriteData, EM_Rt, EM_WriteReg,
               EM_MemRead, EM_MemWrite, EM_RegWrite, EM_MemtoReg, EM_Fault
    );

    modport slave (
        input  stall, flush, EX_Valid, EX_ALUResult, EX_WriteData, EX_Rt, EX_WriteReg,
               EX_MemRead, EX_MemWrite, EX_RegWrite, EX_MemtoReg,
               WB_RegWrite, WB_WriteReg, WB_Result,
        output EM_Valid, EM_ALUResult, EM_WriteData, EM_Rt, EM_WriteReg,
               EM_MemRead, EM_MemWrite, EM_RegWrite, EM_MemtoReg, EM_Fault
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with WB store-data forwarding, stall/flush and access-fault squashing.
// Define EX_MEM_PERF_CNT_EN to add load/store/bubble performance counters.
module ex_mem_stage #(
    parameter int unsigned MEM_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst,
    ex_mem_if.slave     bus
`ifdef EX_MEM_PERF_CNT_EN
    ,
    output logic [31:0] perf_load_cnt,
    output logic [31:0] perf_store_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    typedef struct packed {
        logic        valid;
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [4:0]  rt;
        logic [4:0]  write_reg;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
        logic        fault;
    } em_t;

    em_t  em_q;
    em_t  cap_c;
    logic fault_c;
    logic fwd_ex_c;
    logic fwd_hold_c;

    // Next stage contents for a capture edge; a non-valid EX yields a bubble.
    always_comb begin
        fault_c    = (bus.EX_MemRead | bus.EX_MemWrite) &
                     ((bus.EX_ALUResult[1:0] != 2'b00) |
                      (32'(bus.EX_ALUResult[31:2]) >= MEM_WORDS));
        fwd_ex_c   = bus.EX_MemWrite & bus.WB_RegWrite &
                     (bus.WB_WriteReg == bus.EX_Rt) & (bus.EX_Rt != 5'd0);
        fwd_hold_c = em_q.valid & em_q.mem_write & bus.WB_RegWrite &
                     (bus.WB_WriteReg == em_q.rt) & (em_q.rt != 5'd0);
        cap_c      = '0;
        if (bus.EX_Valid) begin
            cap_c.valid      = 1'b1;
            cap_c.alu_result = bus.EX_ALUResult;
            cap_c.write_data = fwd_ex_c ? bus.WB_Result : bus.EX_WriteData;
            cap_c.rt         = bus.EX_Rt;
            cap_c.write_reg  = bus.EX_WriteReg;
            cap_c.mem_read   = bus.EX_MemRead & ~fault_c;
            cap_c.mem_write  = bus.EX_MemWrite & ~fault_c;
            cap_c.reg_write  = bus.EX_RegWrite & (bus.EX_WriteReg != 5'd0) & ~fault_c;
            cap_c.mem_to_reg = bus.EX_MemtoReg;
            cap_c.fault      = fault_c;
        end
    end

    // A held store keeps picking up WB results so stale rt data never reaches memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            em_q <= '0;
        end else if (bus.flush) begin
            em_q <= '0;
        end else if (bus.stall) begin
            if (fwd_hold_c) begin
                em_q.write_data <= bus.WB_Result;
            end
        end else begin
            em_q <= cap_c;
        end
    end

    assign bus.EM_Valid     = em_q.valid;
    assign bus.EM_ALUResult = em_q.alu_result;
    assign bus.EM_WriteData = em_q.write_data;
    assign bus.EM_Rt        = em_q.rt;
    assign bus.EM_WriteReg  = em_q.write_reg;
    assign bus.EM_MemRead   = em_q.mem_read;
    assign bus.EM_MemWrite  = em_q.mem_write;
    assign bus.EM_RegWrite  = em_q.reg_write;
    assign bus.EM_MemtoReg  = em_q.mem_to_reg;
    assign bus.EM_Fault     = em_q.fault;

`ifdef EX_MEM_PERF_CNT_EN
    // Counted only on capture edges; faulting accesses are not counted as loads/stores.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_load_cnt   <= '0;
            perf_store_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else if (!bus.stall) begin
            if (bus.flush || !bus.EX_Valid) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end else if (!fault_c) begin
                if (bus.EX_MemRead)  perf_load_cnt  <= perf_load_cnt + 32'd1;
                if (bus.EX_MemWrite) perf_store_cnt <= perf_store_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline register of the 5-stage MIPS core, between the ALU (EX) and the data/instruction memory controller (MEM).
- Captures EX results and control each cycle, with stall/flush handling.
- Forwards the WB result into store data at capture time, and also while a store is held by a stall.
- Flags misaligned or out-of-range data accesses and suppresses their memory and register side effects.

Parameters:
MEM_WORDS, 512, number of 32-bit data-memory words; word index ALUResult[31:2] >= MEM_WORDS is out of range

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
stall  input  1  hold all EM_* registers
flush  input  1  replace stage contents with a bubble
EX_Valid  input  1  EX holds a real instruction
EX_ALUResult  input  32  ALU result / memory address
EX_WriteData  input  32  store data (rt value from EX)
EX_Rt  input  5  rt register number of store
EX_WriteReg  input  5  destination register
EX_MemRead  input  1  load
EX_MemWrite  input  1  store
EX_RegWrite  input  1  writes register file
EX_MemtoReg  input  1  WB selects memory data
WB_RegWrite  input  1  WB stage writing register file
WB_WriteReg  input  5  WB destination
WB_Result  input  32  WB write value
EM_Valid  output  1  stage holds a real instruction
EM_ALUResult  output  32  registered address/result
EM_WriteData  output  32  registered (forwarded) store data
EM_Rt  output  5  registered rt
EM_WriteReg  output  5  registered destination
EM_MemRead  output  1  load enable to memory
EM_MemWrite  output  1  store enable to memory
EM_RegWrite  output  1  registered RegWrite
EM_MemtoReg  output  1  registered MemtoReg
EM_Fault  output  1  access fault (misaligned or out of range)

Behaviour:
- Reset: all EM_* outputs are 0, asynchronously.
- Latency: 1 cycle, EX to EM.
- Priority per edge: rst > flush > stall > capture.
- flush: every EM_* output becomes 0 (bubble). flush overrides stall in the same cycle.
- Stall hold: when stall=1, all EM_* registers hold, with one exception:
  - If EM_Valid & EM_MemWrite & WB_RegWrite & (WB_WriteReg == EM_Rt) & (EM_Rt != 0), then EM_WriteData <= WB_Result.
  - This prevents stale store data across multi-cycle stalls.
- Capture with EX_Valid=0: same as flush.
- Capture with EX_Valid=1:
  - EM_Valid = 1.
  - All fields copied from EX.
  - Store-data forwarding: if EX_MemWrite & WB_RegWrite & (WB_WriteReg == EX_Rt) & (EX_Rt != 0), then EM_WriteData = WB_Result; otherwise EM_WriteData = EX_WriteData.
  - EM_RegWrite is forced 0 when EX_WriteReg == 0.
- Fault, evaluated at capture:
  - fault = (EX_MemRead | EX_MemWrite) & ((EX_ALUResult[1:0] != 0) | (EX_ALUResult[31:2] >= MEM_WORDS)).
  - When fault is set: EM_Fault=1, and EM_MemRead, EM_MemWrite, EM_RegWrite are all forced 0. EM_ALUResult still holds the faulting address; EM_Valid stays 1.
  - Non-memory instructions never fault, regardless of address.
- EM_Fault is held under stall and cleared by flush, reset, or the next capture without a fault.
- Reset during a stall or mid-flush: outputs go to 0 immediately; there is no partial state.

Optional Feature:
- Macro: EX_MEM_PERF_CNT_EN.
- When defined, three 32-bit outputs are added:
  - perf_load_cnt, perf_store_cnt, perf_bubble_cnt.
  - They increment on each capture edge (stall=0, rst=0) of a non-faulting load, a non-faulting store, and a bubble (flush or EX_Valid=0) respectively.
  - Counters wrap at 2^32 and are reset to 0 by rst.
- When undefined, these ports and counters do not exist, and the block's behaviour is otherwise identical.

Test Plan:
- Reset: rst=1 with all EX inputs non-zero -> all EM_* = 0 asynchronously; they stay 0 until the first capture after rst falls.
- Store capture with forwarding:
  - Stimulus: EX_Valid=1, EX_MemWrite=1, EX_Rt=5, EX_WriteData=0x11111111, EX_ALUResult=0x40; WB_RegWrite=1, WB_WriteReg=5, WB_Result=0xCAFEF00D.
  - Response, next cycle: EM_MemWrite=1, EM_WriteData=0xCAFEF00D, EM_ALUResult=0x40.
  - Repeat with WB_WriteReg=0 and EX_Rt=0 -> EM_WriteData=0x11111111.
- Stall-hold forwarding:
  - Stimulus: store to 0x80 with EM_Rt=8 held by stall=1 for 3 cycles; WB writes r8=0x12345678 in cycle 2.
  - Response: EM_WriteData becomes 0x12345678; every other field is unchanged during the stall.
- Faults:
  - Load at 0x42 -> EM_Fault=1, EM_MemRead=0, EM_RegWrite=0.
  - Store at 0x800 with MEM_WORDS=512 -> EM_Fault=1, EM_MemWrite=0.
  - ALU op with result 0x43 -> EM_Fault=0.
- flush with stall:
  - Stimulus: EM holds a valid store; flush=1 and stall=1 on the same edge.
  - Response: all EM_* = 0.
- Register-zero write: EX_RegWrite=1, EX_WriteReg=0 -> EM_RegWrite=0.
  - With EX_MEM_PERF_CNT_EN defined, 2 loads, 1 store and 1 bubble give counts 2/1/1.
